// File: rtl/run_sequencer_pkg.sv
// rtl/run_sequencer_pkg.sv - shared state encoding and default widths for the run sequencer
package run_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    localparam int CNT_W_DEF  = 11;

    // The FSM's clock_count stops at 2**CNT_W-1 (its STOP_COUNT); the watchdog limit sits one
    // bit wider so a healthy run always raises done before the watchdog can fire.
    localparam int TIMEOUT_DEF = 2 ** (CNT_W_DEF + 1) - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - host-side load stream, run control and result bundle
interface run_sequencer_if
    import run_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              load_req;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              go;
    logic              ack;
    logic              result_valid;
    logic [CNT_W-1:0]  cycles;
    logic              timeout_err;

    modport master (
        output load_req, wr_valid, wr_data, go, ack,
        input  wr_ready, result_valid, cycles, timeout_err
    );

    modport slave (
        input  load_req, wr_valid, wr_data, go, ack,
        output wr_ready, result_valid, cycles, timeout_err
    );
endinterface

// File: rtl/run_sequencer_rise_detect.sv
// rtl/run_sequencer_rise_detect.sv - registered rising-edge detector for a single level input
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - loads the data memory, launches the measurement FSM and captures its count
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    run_sequencer_if.slave    host,
    input  logic              fsm_done,
    input  logic [CNT_W-1:0]  fsm_count,
    output logic              load_mem,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start,
    output logic              busy
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [ADDR_W:0]  nwords;
    logic [WD_W-1:0]  wdog;
    logic [CNT_W-1:0] cycles_q;
    logic             timeout_q;
    logic             wr_ready_i, result_valid_i;
    logic             accept, done_rise, wd_expired;

    rise_detect u_done_rise (
        .clk   (clk),
        .reset (reset),
        .d     (fsm_done),
        .rise  (done_rise)
    );

    assign accept     = wr_ready_i & host.wr_valid;
    assign wd_expired = (wdog == WD_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (host.load_req)                 state_next = ST_LOAD;
                else if (host.go && nwords != '0)  state_next = ST_START;
            end
            ST_LOAD:   if (!host.load_req)            state_next = ST_IDLE;
            ST_START:                                  state_next = ST_WAIT;
            ST_WAIT:   if (done_rise || wd_expired)   state_next = ST_REPORT;
            ST_REPORT: if (host.ack)                  state_next = ST_IDLE;
            default:                                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_mem       = 1'b0;
        wr_ready_i     = 1'b0;
        start          = 1'b0;
        result_valid_i = 1'b0;
        busy           = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                load_mem   = 1'b1;
                wr_ready_i = ~nwords[ADDR_W];
            end
            ST_START:  start          = 1'b1;
            ST_REPORT: result_valid_i = 1'b1;
            default: ;
        endcase
    end

    // nwords doubles as the write pointer; its top bit marks a full memory so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nwords    <= '0;
            wdog      <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && host.load_req) nwords <= '0;
            else if (accept)                       nwords <= nwords + (ADDR_W + 1)'(1);

            if (state == ST_START)                     wdog <= '0;
            else if (state == ST_WAIT && !wd_expired)  wdog <= wdog + WD_W'(1);

            if (state == ST_WAIT && (done_rise || wd_expired)) begin
                cycles_q  <= fsm_count;
                timeout_q <= ~done_rise;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= nwords[ADDR_W-1:0];
                mem_wdata <= host.wr_data;
            end
        end
    end

    assign host.wr_ready     = wr_ready_i;
    assign host.result_valid = result_valid_i;
    assign host.cycles       = cycles_q;
    assign host.timeout_err  = timeout_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed self-checking bench for run_sequencer
module tb_run_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fsm_done = 1'b0;
    logic [10:0] fsm_count = '0;
    logic        load_mem, mem_we, start, busy;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cnt = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int accepted;
    int k;

    run_sequencer_if #(.DATA_W(8), .CNT_W(11)) host_if ();

    run_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host_if),
        .fsm_done  (fsm_done),
        .fsm_count (fsm_count),
        .load_mem  (load_mem),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .start     (start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_wdata));
            wr_cyc.push_back(cyc);
        end
        if (start) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_words(input int n_offer, input int base, output int n_acc);
        n_acc = 0;
        @(negedge clk);
        host_if.load_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n_offer; i++) begin
            host_if.wr_valid = 1'b1;
            host_if.wr_data  = 8'(base + n_acc);
            if (i == 64) check("ready_low_at_full", host_if.wr_ready, 0);
            if (host_if.wr_ready) n_acc++;
            @(negedge clk);
        end
        host_if.wr_valid = 1'b0;
        host_if.load_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        host_if.load_req = 1'b0;
        host_if.wr_valid = 1'b0;
        host_if.wr_data  = '0;
        host_if.go       = 1'b0;
        host_if.ack      = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_result_valid", host_if.result_valid, 0);
        check("rst_wr_ready", host_if.wr_ready, 0);
        reset = 1'b1;

        // four-word load
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        load_words(4, 8'h11, accepted);
        check("load4_writes", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            check("load4_addr", wr_addr[i], i);
            check("load4_data", wr_data[i], 8'h11 + i);
        end
        if (wr_cyc.size() == 4) check("load4_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
        check("load4_nwords", int'(dut.nwords), 4);
        check("load4_back_idle", busy, 0);

        // full load with two extra words offered
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        load_words(66, 0, accepted);
        check("load64_accepted", accepted, 64);
        check("load64_writes", wr_addr.size(), 64);
        if (wr_addr.size() == 64) begin
            check("load64_last_addr", wr_addr[63], 63);
            check("load64_last_data", wr_data[63], 63);
            check("load64_back_to_back", wr_cyc[63] - wr_cyc[0], 63);
        end

        // normal run
        @(negedge clk);
        host_if.go = 1'b1;
        @(negedge clk);
        host_if.go = 1'b0;
        check("run_start_pulse", start, 1);
        check("run_busy", busy, 1);
        @(negedge clk);
        check("run_start_one_cycle", start, 0);
        repeat (3) @(negedge clk);
        fsm_count = 11'h3E9;
        fsm_done  = 1'b1;
        @(negedge clk);
        check("run_result_valid", host_if.result_valid, 1);
        check("run_cycles", host_if.cycles, 11'h3E9);
        check("run_timeout_err", host_if.timeout_err, 0);
        check("run_start_count", start_cnt, 1);
        @(negedge clk);
        check("run_result_held", host_if.result_valid, 1);
        host_if.ack = 1'b1;
        host_if.go  = 1'b1;
        @(negedge clk);
        host_if.ack = 1'b0;
        host_if.go  = 1'b0;
        check("ack_result_low", host_if.result_valid, 0);
        check("ack_busy_low", busy, 0);
        @(negedge clk);
        check("ack_go_not_honoured", busy, 0);
        check("ack_start_count", start_cnt, 1);

        // stale done held high: watchdog must end the run
        fsm_count = 11'h155;
        host_if.go = 1'b1;
        @(negedge clk);
        host_if.go = 1'b0;
        check("wd_start_pulse", start, 1);
        k = 0;
        while (!host_if.result_valid && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("wd_latency", k, 4097);
        check("wd_timeout_err", host_if.timeout_err, 1);
        check("wd_cycles", host_if.cycles, 11'h155);
        host_if.ack = 1'b1;
        @(negedge clk);
        host_if.ack = 1'b0;
        check("wd_ack_idle", busy, 0);

        // reset mid-WAIT
        host_if.go = 1'b1;
        @(negedge clk);
        host_if.go = 1'b0;
        repeat (5) @(negedge clk);
        check("midwait_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cycles", host_if.cycles, 0);
        check("arst_timeout_err", host_if.timeout_err, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_start", start, 0);
        @(negedge clk);
        reset = 1'b1;
        check("arst_nwords", int'(dut.nwords), 0);
        host_if.go = 1'b1;
        @(negedge clk);
        host_if.go = 1'b0;
        check("empty_go_ignored", busy, 0);
        @(negedge clk);
        check("empty_go_no_start", start_cnt, 3);

        // load_req and go together
        host_if.load_req = 1'b1;
        host_if.go       = 1'b1;
        @(negedge clk);
        host_if.go = 1'b0;
        check("both_load_mem", load_mem, 1);
        check("both_no_start", start, 0);
        @(negedge clk);
        check("both_still_load", load_mem, 1);
        host_if.load_req = 1'b0;
        @(negedge clk);
        check("both_back_idle", busy, 0);
        check("both_start_count", start_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Front-end controller that sits directly upstream of the measurement FSM. It streams a block of words into the shared data memory during a load phase, then issues a one-cycle `start` pulse to the FSM. It waits for the FSM's `done` and captures the FSM's `clock_count` as a result for the host. It owns the `load_mem` and `start` inputs of the FSM and consumes its `done` and `clock_count` outputs.

## Interface
- `DATA_W`, 8, width of memory write data
- `ADDR_W`, 6, memory address width; depth = 2**ADDR_W words
- `CNT_W`, 11, width of the FSM cycle count
- `TIMEOUT`, 4095, max cycles to wait for `done` before flagging an error (fits 12 bits)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; low forces reset immediately, release synchronous to `clk`
- `load_req` in 1: host level request to enter load phase
- `wr_valid` in 1: host write word valid
- `wr_data` in DATA_W: host write word
- `wr_ready` out 1: sequencer accepts a word this cycle
- `go` in 1: host request to launch a run
- `ack` in 1: host acknowledges the result
- `fsm_done` in 1: FSM `done`
- `fsm_count` in CNT_W: FSM `clock_count`
- `load_mem` out 1: to FSM/memory, high while in LOAD
- `mem_we` out 1: memory write strobe, registered
- `mem_addr` out ADDR_W: memory write address, registered
- `mem_wdata` out DATA_W: memory write data, registered
- `start` out 1: one-cycle pulse to FSM
- `busy` out 1: state is not IDLE
- `result_valid` out 1: `cycles` and `timeout_err` are valid
- `cycles` out CNT_W: captured `fsm_count`
- `timeout_err` out 1: run ended by watchdog, not `done`

## Operation
- States: IDLE, LOAD, START, WAIT, REPORT. Encoded 3-bit.
- IDLE: if `load_req` then LOAD, clearing the word counter `nwords` and the write pointer. Else if `go` and `nwords != 0` then START. `go` with `nwords == 0` is ignored. `load_req` wins over `go` when both are high.
- LOAD:
  - `load_mem = 1`.
  - `wr_ready = 1` while `nwords < 2**ADDR_W`.
  - On accept (`wr_valid & wr_ready`): next cycle `mem_we = 1`, `mem_addr` = pointer, `mem_wdata` = `wr_data`; pointer and `nwords` increment.
  - At full, `wr_ready = 0`; extra words are not accepted and the pointer does not wrap.
  - `load_req` low: go to IDLE with `nwords` kept. A word accepted on that same cycle is still written.
- START: `start = 1` for exactly one cycle, clear the watchdog, then WAIT.
- WAIT:
  - Rising-edge detect on `fsm_done` (registered `done_q`); a stale high `done` from a previous run must not count.
  - On an edge: `cycles <= fsm_count`, `timeout_err <= 0`, go to REPORT.
  - If the watchdog reaches `TIMEOUT` first: `cycles <= fsm_count`, `timeout_err <= 1`, go to REPORT.
  - `go` and `load_req` are ignored here.
- REPORT: `result_valid = 1` and held until `ack`, then IDLE. `cycles` and `timeout_err` stay stable until the next capture.
- Reset at any point, including mid-load or mid-run: state IDLE, `nwords` 0, all outputs 0.

## Timing
- Reset values: every output 0.
- Accept to memory write: 1 cycle. Back-to-back accepts give one write per cycle.
- `go` sampled in IDLE at edge n gives `start` high in cycle n+1 only; `busy` is high from n+1.
- `fsm_done` edge seen at edge m gives `result_valid` high from m+1.
- `ack` at edge k gives `result_valid` and `busy` low from k+1. `go` at the same edge is not honoured until IDLE.
- Watchdog counts WAIT cycles starting at 0. Timeout fires on the cycle the count equals `TIMEOUT`.

## Structure
- Shared package: state encoding constants, `CNT_W` default, and a `STOP_COUNT`-compatible note tying `TIMEOUT` above the FSM's maximum count.
- One sub-module: `rise_detect` (registered single-bit edge detector, async active-low reset), used on `fsm_done`.

## Test plan
- Reset then load 4 words 0x11..0x14 with `wr_valid` held -> `mem_we` for 4 consecutive cycles, addresses 0..3, `nwords` = 4.
- Load 64 words with 2 extra offered -> exactly 64 writes, `wr_ready` low after the 64th, last address 63.
- `go` after load; FSM model asserts `done` with `fsm_count` = 0x3E9 -> single `start` pulse, `result_valid` with `cycles` = 0x3E9, `timeout_err` = 0; `ack` -> IDLE.
- `fsm_done` held high from the previous run entering WAIT and the model never re-raises it -> no false capture, `timeout_err` = 1 after 4095 WAIT cycles.
- `go` with `nwords` = 0, and `load_req` plus `go` together -> first ignored, second enters LOAD with no `start`.
- Drop `reset` low mid-WAIT -> all outputs 0 immediately; after release, a new `go` with `nwords` = 0 is ignored.
